// File: rtl/serial_add_seq.sv
// serial_add_seq: 2-deep operand FIFO, add sequencer and result holder
// wrapped around an external bit-serial adder.
module serial_add_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             add_rst,
  output logic             add_load,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             busy,
  output logic [7:0]       ops_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [WIDTH-1:0] r_fa [2];
  logic [WIDTH-1:0] r_fb [2];
  logic             r_wp;
  logic             r_rp;
  logic [1:0]       r_cnt;
  logic [CNT_W-1:0] r_sh;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic [WIDTH-1:0] r_res_sum;
  logic             r_res_valid;
  logic [7:0]       r_ops;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_hs;
  logic             w_last;

  assign w_full  = (r_cnt == 2'd2);
  assign w_empty = (r_cnt == 2'd0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = (r_state == S_CAPTURE);
  assign w_hs    = r_res_valid && res_ready;
  assign w_last  = (r_sh == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (!w_empty) w_nxt = S_CLEAR;
      S_CLEAR:   w_nxt = S_LOAD;
      S_LOAD:    w_nxt = S_SHIFT;
      S_SHIFT:   if (w_last) w_nxt = S_CAPTURE;
      S_CAPTURE: w_nxt = S_HOLD;
      S_HOLD:
        if (w_hs) w_nxt = w_empty ? S_IDLE : S_CLEAR;
      default:   w_nxt = S_IDLE;
    endcase
  end

  // pushes are gated by count only, so push+pop can only meet at count 1
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop)  r_rp <= ~r_rp;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fa[r_wp] <= in_a;
      r_fb[r_wp] <= in_b;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_sh        <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_res_sum   <= '0;
      r_res_valid <= 1'b0;
      r_ops       <= 8'd0;
    end else begin
      if (r_state == S_LOAD)       r_sh <= '0;
      else if (r_state == S_SHIFT) r_sh <= r_sh + CNT_W'(1);
      // operands stay parked on the adder until the next CLEAR
      if (r_state == S_CLEAR) begin
        r_add_a <= r_fa[r_rp];
        r_add_b <= r_fb[r_rp];
      end
      if (r_state == S_CAPTURE) begin
        r_res_sum   <= add_sum;
        r_res_valid <= 1'b1;
      end else if (r_state == S_HOLD && w_hs) begin
        r_res_valid <= 1'b0;
        r_ops       <= r_ops + 8'd1;
      end
    end
  end

  assign in_ready  = !w_full;
  assign add_rst   = (r_state == S_IDLE) || (r_state == S_CLEAR);
  assign add_load  = (r_state == S_LOAD);
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign res_valid = r_res_valid;
  assign res_sum   = r_res_sum;
  assign busy      = (r_state != S_IDLE);
  assign ops_done  = r_ops;

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
- Sequencer and operand/result buffer wrapped around the 8-bit serial adder.
- Upstream side: accepts operand pairs through a valid/ready handshake and queues them in a 2-entry FIFO.
- Adder side: drives the adder's clear, load and parallel operand inputs, then counts WIDTH shift cycles.
- Downstream side: captures the adder's parallel sum and holds it on a valid/ready result port until consumed.

Parameters:
- WIDTH, 8, operand/sum width; also the number of shift cycles per add.
- CNT_W, 4, shift-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; equals (fifo_count != 2).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- add_rst  out  1  clear to adder registers (carry, shift regs, sum).
- add_load  out  1  parallel-load strobe to adder.
- add_a  out  WIDTH  operand A to adder.
- add_b  out  WIDTH  operand B to adder.
- add_sum  in  WIDTH  adder parallel sum output.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_sum  out  WIDTH  captured sum (mod 2^WIDTH).
- busy  out  1  state != IDLE.
- ops_done  out  8  completed-result counter.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; FIFO empty (pointers and count 0); shift counter 0.
  - res_valid=0, res_sum=0, add_load=0, add_a=0, add_b=0, ops_done=0.
  - add_rst=1 (high while in IDLE).
  - A reset mid-operation aborts the add; queued operands and any unconsumed result are discarded.
- FIFO:
  - 2 entries of {a,b}; push on in_valid && in_ready.
  - Pop only in CAPTURE.
  - in_ready depends on count only: a push is refused when full even in a CAPTURE cycle. The push/pop in the same cycle case arises only at count 1, leaving count at 1.
- States (all outputs registered/Moore):
  - IDLE: add_rst=1. Move to CLEAR when FIFO non-empty.
  - CLEAR: add_rst=1 for exactly 1 cycle. Move to LOAD.
  - LOAD: add_rst=0, add_load=1, add_a/add_b = FIFO head. Move to SHIFT and clear the counter.
  - SHIFT: add_load=0, add_a/add_b held at head. Counter increments each cycle; move to CAPTURE when counter==WIDTH-1, i.e. exactly WIDTH SHIFT cycles.
  - CAPTURE: on the exit edge, res_sum<=add_sum, res_valid<=1, FIFO pop. Move to HOLD.
  - HOLD: wait for res_valid && res_ready. On handshake: res_valid<=0, ops_done<=ops_done+1 (wraps 255->0). Then go to CLEAR if FIFO is non-empty, else IDLE.
  - In HOLD, res_sum stays stable and no new add starts until the result is consumed. Throughput is one add per (WIDTH+4) cycles minimum.
- Latency:
  - Operand pushed at edge E0 into an empty FIFO in IDLE gives CLEAR after E1, LOAD after E2, SHIFT after E3, and res_valid=1 after edge E0+WIDTH+4.
  - For WIDTH=8 that is 12 cycles.
  - With res_ready held high, res_valid is high for exactly 1 cycle.
- Arithmetic: the block does no arithmetic. res_sum mirrors add_sum sampled on the CAPTURE exit edge; the carry-out is dropped.
- in_valid while in_ready=0: data is ignored and not latched. The source must hold it.

Test Plan:
- Single op: reset, push a=8'h35, b=8'h4A with res_ready=1 (behavioural adder model) -> res_valid rises 12 cycles after the push edge, res_sum=8'h7F, ops_done=1. add_rst pulses 1 cycle before add_load; add_load is high exactly 1 cycle.
- Overflow wrap: a=8'hFF, b=8'h02 -> res_sum=8'h01. A subsequent a=8'h00, b=8'h00 gives 8'h00, proving CLEAR zeroed the carry.
- Back-pressure/FIFO full: push 3 pairs back-to-back with res_ready=0 -> in_ready drops after 2 accepts; the third is held and accepted only after the CAPTURE pop. The first result stays stable in HOLD for 20 cycles. Releasing res_ready then yields all 3 sums in order, with ops_done=3.
- Push during CAPTURE: count=1 and a push in the CAPTURE cycle -> count remains 1, and the next op starts from HOLD straight to CLEAR.
- Reset mid-SHIFT: assert rst at SHIFT count 4 -> all outputs are at reset values immediately (asynchronously) and the FIFO is empty. After release, a new op completes normally.
- ops_done wrap: 256 completed handshakes -> ops_done=0.
